// File: rtl/lsu.sv
// lsu: load/store unit between EXU and WBU with a timeout on the memory response.
// Optional LSU_MISALIGN_CHECK_EN: misaligned half/word accesses skip the bus and report out_misalign.
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc,
  input  logic [31:0] EX_result,
  input  logic [31:0] rs2_value,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic        R_wen,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [3:0]  csr_wen,
  input  logic [31:0] csrs,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_next,
  output logic [4:0]  rd_next,
  output logic        R_wen_next,
  output logic [3:0]  csr_wen_next,
  output logic [31:0] csrs_next,
  output logic [31:0] wb_data,
  output logic        out_err,
  output logic        out_misalign
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, OUT = 2'd3;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0]    state, sz, off;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, data_q, shifted, load_data;
  logic [2:0]    f3_q;
  logic          st_q, req, accept, mem_op, mis_in;
  // Access size: 0 byte, 1 half, 2 word; stores only know sb/sh, everything else is sw.
  function automatic logic [1:0] size_of(input logic st, input logic [2:0] f3);
    return st ? (f3 == 3'b000 ? 2'd0 : f3 == 3'b001 ? 2'd1 : 2'd2)
              : (f3[1:0] == 2'b00 ? 2'd0 : f3[1:0] == 2'b01 ? 2'd1 : 2'd2);
  endfunction
  assign accept = in_valid & in_ready;
  assign mem_op = mem_wen | mem_ren;
  assign req    = state == REQ;
`ifdef LSU_MISALIGN_CHECK_EN
  logic [1:0] in_sz;
  assign in_sz  = size_of(mem_wen, funct3);
  assign mis_in = mem_op & (in_sz == 2'd1 ? EX_result[0] : in_sz == 2'd2 ? |EX_result[1:0] : 1'b0);
  always_ff @(posedge clk)
    if (rst) out_misalign <= 1'b0;
    else if (accept) out_misalign <= mis_in;
`else
  assign mis_in       = 1'b0;
  assign out_misalign = 1'b0;
`endif
  // Byte offset truncated to the natural alignment of the access size.
  always_comb begin
    sz        = size_of(st_q, f3_q);
    off       = sz == 2'd2 ? 2'd0 : sz == 2'd1 ? {addr_q[1], 1'b0} : addr_q[1:0];
    shifted   = mem_resp_rdata >> {off, 3'b000};
    load_data = f3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                f3_q == 3'b100 ? {24'd0, shifted[7:0]} :
                f3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                f3_q == 3'b101 ? {16'd0, shifted[15:0]} : shifted;
  end
  assign in_ready      = state == IDLE;
  assign out_valid     = state == OUT;
  assign mem_req_valid = req;
  assign mem_req_wen   = req & st_q;
  assign mem_req_addr  = req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_req_wmask = !req ? 4'b0000 : sz == 2'd0 ? 4'b0001 << off : sz == 2'd1 ? 4'b0011 << off : 4'b1111;
  assign mem_req_wdata = !req ? 32'd0 : sz == 2'd0 ? {4{data_q[7:0]}} : sz == 2'd1 ? {2{data_q[15:0]}} : data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      f3_q         <= '0;
      st_q         <= 1'b0;
      pc_next      <= '0;
      rd_next      <= '0;
      R_wen_next   <= 1'b0;
      csr_wen_next <= '0;
      csrs_next    <= '0;
      wb_data      <= '0;
      out_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state        <= mem_op & ~mis_in ? REQ : OUT;
          cnt          <= '0;
          addr_q       <= EX_result;
          data_q       <= rs2_value;
          f3_q         <= funct3;
          st_q         <= mem_wen;
          pc_next      <= pc;
          rd_next      <= rd;
          R_wen_next   <= R_wen & ~mis_in;
          csr_wen_next <= csr_wen;
          csrs_next    <= csrs;
          wb_data      <= EX_result;
          out_err      <= 1'b0;
        end
        REQ: if (mem_req_ready) state <= WAIT;
        WAIT: if (mem_resp_valid) begin
          state   <= OUT;
          wb_data <= st_q ? addr_q : load_data;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state      <= OUT;
          out_err    <= 1'b1;
          wb_data    <= '0;
          R_wen_next <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu; expected WBU results are queued at issue and popped on out_valid.
// Default build exercises LSU_MISALIGN_CHECK_EN undefined; the misaligned case follows the macro.
module tb_lsu;
  localparam int TO = 255;
  logic clk = 1'b0, rst;
  logic in_valid, in_ready, R_wen, mem_wen, mem_ren;
  logic [31:0] pc, EX_result, rs2_value, csrs;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [3:0] csr_wen;
  logic mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [3:0] mem_req_wmask;
  logic out_valid, out_ready, R_wen_next, out_err, out_misalign;
  logic [31:0] pc_next, csrs_next, wb_data;
  logic [4:0] rd_next;
  logic [3:0] csr_wen_next;
  logic [107:0] sb_q[$];
  logic [107:0] got, exp;
  logic [68:0] req;
  int n_chk = 0, n_fail = 0;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .EX_result(EX_result),
    .rs2_value(rs2_value), .rd(rd), .funct3(funct3), .R_wen(R_wen), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .csr_wen(csr_wen), .csrs(csrs), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .pc_next(pc_next), .rd_next(rd_next),
    .R_wen_next(R_wen_next), .csr_wen_next(csr_wen_next), .csrs_next(csrs_next), .wb_data(wb_data),
    .out_err(out_err), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  function automatic logic [107:0] pack(input logic [31:0] wb, input logic e, m, rw,
                                        input logic [4:0] r, input logic [31:0] p);
    return {wb, e, m, rw, r, p, r[3:0], ~p};
  endfunction

  task automatic accept_op(input logic [31:0] p, ex, d, input logic [4:0] r, input logic [2:0] f3,
                           input logic rw, mw, mr, output bit ok);
    ok = 0;
    pc = p; EX_result = ex; rs2_value = d; rd = r; funct3 = f3;
    R_wen = rw; mem_wen = mw; mem_ren = mr; csr_wen = r[3:0]; csrs = ~p; in_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 0;
    pc = $urandom; EX_result = $urandom; rs2_value = $urandom; funct3 = 3'($urandom);
    R_wen = 0; mem_wen = 0; mem_ren = 0; csrs = $urandom;
  endtask

  // Serve one bus request: hold ready low rdly cycles, then respond after wdly cycles if asked.
  task automatic bus(input int rdly, wdly, input bit respond, input logic [31:0] rdata,
                     output logic [68:0] r, output bit ok);
    ok = mem_req_valid;
    r = {mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata};
    repeat (rdly) begin
      @(negedge clk);
      if (!mem_req_valid || {mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata} !== r) ok = 0;
    end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    if (mem_req_valid) ok = 0;
    if (respond) begin
      repeat (wdly) @(negedge clk);
      mem_resp_rdata = rdata; mem_resp_valid = 1;
      @(negedge clk);
      mem_resp_valid = 0; mem_resp_rdata = $urandom;
    end
  endtask

  task automatic get_out(input int bound, output logic [107:0] g, output int waited);
    waited = -1; g = 'x;
    for (int k = 0; k <= bound; k++) begin
      if (out_valid) begin
        waited = k;
        g = pack(wb_data, out_err, out_misalign, R_wen_next, rd_next, pc_next);
        g[35:0] = {csr_wen_next, csrs_next};
        break;
      end
      @(negedge clk);
    end
    if (waited >= 0) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 0; pc = 0; EX_result = 0; rs2_value = 0; rd = 0; funct3 = 0;
    R_wen = 0; mem_wen = 0; mem_ren = 0; csr_wen = 0; csrs = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({in_ready, out_valid, mem_req_valid, mem_req_wen, out_err, out_misalign, R_wen_next} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=1000000",
               {in_ready, out_valid, mem_req_valid, mem_req_wen, out_err, out_misalign, R_wen_next});
    end
    n_chk++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wmask, wb_data, pc_next, rd_next, csr_wen_next, csrs_next} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h exp=0",
               {mem_req_addr, mem_req_wdata, mem_req_wmask, wb_data, pc_next, rd_next, csr_wen_next, csrs_next});
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_alu;
    bit ok;
    int w;
    accept_op(32'h100, 32'h1234, 32'h55, 5'd5, 3'b010, 1, 0, 0, ok);
    sb_q.push_back(pack(32'h1234, 0, 0, 1, 5'd5, 32'h100));
    n_chk++;
    if ({ok, out_valid, in_ready, mem_req_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL alu_handshake got=%b exp=1100", {ok, out_valid, in_ready, mem_req_valid});
    end
    get_out(4, got, w);
    exp = sb_q.pop_front();
    n_chk++;
    if (w !== 0 || got !== exp) begin
      n_fail++;
      $display("FAIL alu_out got=%h exp=%h wait=%0d", got, exp, w);
    end
  endtask

  task automatic test_store;
    logic [31:0] a[4] = '{32'h1003, 32'h1002, 32'h1004, 32'h4000};
    logic [31:0] d[4] = '{32'h000000AB, 32'h1234CDEF, 32'h89ABCDEF, 32'hCAFEF00D};
    logic [2:0] f[4] = '{3'b000, 3'b001, 3'b010, 3'b010};
    logic mr[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [68:0] er[4] = '{{1'b1, 4'b1000, 32'h1000, 32'hABABABAB}, {1'b1, 4'b1100, 32'h1000, 32'hCDEFCDEF},
                           {1'b1, 4'b1111, 32'h1004, 32'h89ABCDEF}, {1'b1, 4'b1111, 32'h4000, 32'hCAFEF00D}};
    bit ok, bok;
    int w;
    for (int i = 0; i < 4; i++) begin
      accept_op(32'h200 + 32'(4 * i), a[i], d[i], 5'(i + 1), f[i], 1, 1, mr[i], ok);
      sb_q.push_back(pack(a[i], 0, 0, 1, 5'(i + 1), 32'h200 + 32'(4 * i)));
      bus(3, i, 1, 32'hFFFFFFFF, req, bok);
      n_chk++;
      if ({ok, bok, req} !== {2'b11, er[i]}) begin
        n_fail++;
        $display("FAIL store_req[%0d] got=%h exp=%h ok=%b", i, req, er[i], {ok, bok});
      end
      get_out(5, got, w);
      exp = sb_q.pop_front();
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL store_out[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_load;
    logic [31:0] a[6] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2000, 32'h2003};
    logic [31:0] rdv[6] = '{32'h00008000, 32'h00008000, 32'hBEEF0000, 32'h80010000, 32'hDEADBEEF, 32'h7F000000};
    logic [2:0] f[6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000};
    logic [31:0] ew[6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFF8001, 32'hDEADBEEF, 32'h0000007F};
    bit ok, bok;
    int w;
    for (int i = 0; i < 6; i++) begin
      accept_op(32'h300 + 32'(4 * i), a[i], 32'h0, 5'(i + 8), f[i], 1, 0, 1, ok);
      sb_q.push_back(pack(ew[i], 0, 0, 1, 5'(i + 8), 32'h300 + 32'(4 * i)));
      bus(i % 3, i % 2, 1, rdv[i], req, bok);
      n_chk++;
      if ({ok, bok, req[68], req[63:32]} !== {3'b110, 32'h2000}) begin
        n_fail++;
        $display("FAIL load_req[%0d] got=%h exp=0_00002000 ok=%b", i, {req[68], req[63:32]}, {ok, bok});
      end
      get_out(5, got, w);
      exp = sb_q.pop_front();
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL load_out[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_timeout;
    bit ok, bok;
    int w, stray;
    accept_op(32'h400, 32'h2100, 32'h0, 5'd3, 3'b010, 1, 0, 1, ok);
    sb_q.push_back(pack(32'h0, 1, 0, 0, 5'd3, 32'h400));
    bus(0, 0, 0, 32'h0, req, bok);
    get_out(TO + 10, got, w);
    exp = sb_q.pop_front();
    n_chk++;
    if ({ok, bok} !== 2'b11 || w !== TO) begin
      n_fail++;
      $display("FAIL timeout_len got=%0d exp=%0d ok=%b", w, TO, {ok, bok});
    end
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL timeout_out got=%h exp=%h", got, exp);
    end
    stray = 0;
    mem_resp_valid = 1; mem_resp_rdata = 32'h12345678;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) mem_resp_valid = 0;
      stray += int'(out_valid) + int'(!in_ready);
      @(negedge clk);
    end
    n_chk++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL timeout_stray got=%0d exp=0", stray);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int w, bad;
    out_ready = 0;
    accept_op(32'h500, 32'hAAAA0001, 32'h0, 5'd7, 3'b000, 1, 0, 0, ok);
    sb_q.push_back(pack(32'hAAAA0001, 0, 0, 1, 5'd7, 32'h500));
    pc = 32'h504; EX_result = 32'hBBBB0002; rd = 5'd9; funct3 = 3'b000; R_wen = 1;
    mem_wen = 0; mem_ren = 0; csr_wen = 4'd9; csrs = ~32'h504; in_valid = 1;
    mem_resp_valid = 1;
    bad = 0;
    repeat (3) begin
      if (!out_valid || in_ready || wb_data !== 32'hAAAA0001 || rd_next !== 5'd7) bad++;
      @(negedge clk);
    end
    mem_resp_valid = 0;
    n_chk++;
    if (!ok || bad !== 0) begin
      n_fail++;
      $display("FAIL hold_stable got=%0d exp=0 ok=%b", bad, ok);
    end
    sb_q.push_back(pack(32'hBBBB0002, 0, 0, 1, 5'd9, 32'h504));
    out_ready = 1;
    get_out(2, got, w);
    exp = sb_q.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL b2b_first got=%h exp=%h", got, exp);
    end
    n_chk++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_no_accept_in_out got=%b exp=10", {in_ready, out_valid});
    end
    @(negedge clk);
    in_valid = 0;
    get_out(2, got, w);
    exp = sb_q.pop_front();
    n_chk++;
    if (w !== 0 || got !== exp) begin
      n_fail++;
      $display("FAIL b2b_second got=%h exp=%h wait=%0d", got, exp, w);
    end
  endtask

  task automatic test_reset_mid;
    bit ok, bok;
    int w;
    accept_op(32'h600, 32'h3000, 32'h0, 5'd4, 3'b010, 1, 0, 1, ok);
    bus(0, 0, 0, 32'h0, req, bok);
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_chk++;
    if ({ok, bok, in_ready, mem_req_valid, out_valid} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_in_wait got=%b exp=11100", {ok, bok, in_ready, mem_req_valid, out_valid});
    end
    accept_op(32'h604, 32'h3008, 32'h77, 5'd4, 3'b010, 1, 1, 0, ok);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_chk++;
    if ({ok, in_ready, mem_req_valid, out_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_in_req got=%b exp=1100", {ok, in_ready, mem_req_valid, out_valid});
    end
`ifdef LSU_MISALIGN_CHECK_EN
    accept_op(32'h608, 32'h3002, 32'h0, 5'd6, 3'b010, 1, 0, 1, ok);
    sb_q.push_back(pack(32'h3002, 0, 1, 0, 5'd6, 32'h608));
    n_chk++;
    if ({ok, mem_req_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL misalign_no_req got=%b exp=10", {ok, mem_req_valid});
    end
`else
    accept_op(32'h608, 32'h3002, 32'h0, 5'd6, 3'b010, 1, 0, 1, ok);
    sb_q.push_back(pack(32'h11223344, 0, 0, 1, 5'd6, 32'h608));
    bus(1, 1, 1, 32'h11223344, req, bok);
    n_chk++;
    if ({ok, bok, req[68], req[63:32]} !== {3'b110, 32'h3000}) begin
      n_fail++;
      $display("FAIL misalign_req got=%h exp=0_00003000 ok=%b", {req[68], req[63:32]}, {ok, bok});
    end
`endif
    get_out(5, got, w);
    exp = sb_q.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL misalign_out got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_store;
    test_load;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    n_chk++;
    if (sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
